// File: rtl/whackamole_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package whackamole_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_WAIT  = 3'd2,
        S_JUDGE = 3'd3,
        S_GAP   = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam logic [2:0]  NO_MOLE   = 3'd5;
    localparam int unsigned NUM_HOLES = 5;
    // Feedback taps 8,6,5,4 of x^8+x^6+x^5+x^4+1, as a mask over lfsr[7:0].
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running LFSR folded onto holes 0..4, never repeating the previous hole.
module mole_lfsr
    import whackamole_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] prev_pos,
    output logic [2:0] next_pos
);

    logic [7:0] lfsr;
    logic [2:0] raw;
    logic [2:0] cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    always_comb begin
        raw  = lfsr[2:0];
        cand = (raw >= NO_MOLE) ? raw - NO_MOLE : raw;
        if (cand == prev_pos) begin
            next_pos = (cand == 3'(NUM_HOLES - 1)) ? 3'd0 : cand + 3'd1;
        end else begin
            next_pos = cand;
        end
    end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round sequencer: spawns moles, times guess windows, judges hits and keeps score.
module mole_game_ctrl
    import whackamole_pkg::*;
#(
    parameter int unsigned WINDOW_TICKS = 50_000_000,
    parameter int unsigned GAP_TICKS    = 25_000_000,
    parameter int unsigned ROUNDS       = 20,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       soft_rst,
    input  logic       start,
    input  logic [2:0] user_guess,
    input  logic       eval_now,
    output logic       guess_now,
    output logic [2:0] mole_pos,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [7:0] round_cnt,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       game_over
);

    state_t      state;
    state_t      state_n;
    logic [31:0] tick_cnt;
    logic [2:0]  prev_pos;
    logic [2:0]  next_pos;
    logic        accept;
    logic        is_hit;
    logic        last_tick;

    mole_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .prev_pos (prev_pos),
        .next_pos (next_pos)
    );

    assign last_tick = (tick_cnt == '0);
    // The counter still holds its load value only on the first WAIT cycle, whose eval_now is stale.
    assign accept = (state == S_WAIT) && eval_now && (user_guess < NO_MOLE)
                    && (tick_cnt != WINDOW_TICKS - 1);
    assign is_hit = accept && (user_guess == mole_pos);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_SPAWN;
            S_SPAWN: state_n = S_WAIT;
            S_WAIT:  if (accept || last_tick) state_n = S_JUDGE;
            S_JUDGE: state_n = S_GAP;
            S_GAP:   if (last_tick) state_n = (round_cnt == 8'(ROUNDS)) ? S_OVER : S_SPAWN;
            S_OVER:  if (start) state_n = S_SPAWN;
            default: state_n = S_IDLE;
        endcase
        if (soft_rst) state_n = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            prev_pos   <= NO_MOLE;
            guess_now  <= 1'b0;
            mole_pos   <= NO_MOLE;
            score      <= '0;
            misses     <= '0;
            round_cnt  <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else if (soft_rst) begin
            // prev_pos and the LFSR are deliberately left running across a game clear.
            state      <= S_IDLE;
            tick_cnt   <= '0;
            guess_now  <= 1'b0;
            mole_pos   <= NO_MOLE;
            score      <= '0;
            misses     <= '0;
            round_cnt  <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            guess_now  <= (state_n == S_WAIT);
            game_over  <= (state_n == S_OVER);
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        score     <= '0;
                        misses    <= '0;
                        round_cnt <= '0;
                    end
                end
                S_SPAWN: begin
                    mole_pos  <= next_pos;
                    prev_pos  <= next_pos;
                    round_cnt <= sat_inc(round_cnt);
                    tick_cnt  <= WINDOW_TICKS - 1;
                end
                S_WAIT: begin
                    if (state_n == S_JUDGE) begin
                        if (is_hit) begin
                            score     <= sat_inc(score);
                            hit_pulse <= 1'b1;
                        end else begin
                            misses     <= sat_inc(misses);
                            miss_pulse <= 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt - 1;
                    end
                end
                S_JUDGE: begin
                    mole_pos <= NO_MOLE;
                    tick_cnt <= GAP_TICKS - 1;
                end
                S_GAP: begin
                    if (!last_tick) tick_cnt <= tick_cnt - 1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Randomized self-checking bench for mole_game_ctrl against a round-level reference model.
module tb_mole_game_ctrl;

    localparam int unsigned WT   = 8;
    localparam int unsigned GT   = 4;
    localparam int unsigned RN   = 3;
    localparam logic [7:0]  SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       soft_rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] user_guess = 3'd5;
    logic       eval_now = 1'b0;
    logic       guess_now;
    logic [2:0] mole_pos;
    logic [7:0] score;
    logic [7:0] misses;
    logic [7:0] round_cnt;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       game_over;

    mole_game_ctrl #(
        .WINDOW_TICKS (WT),
        .GAP_TICKS    (GT),
        .ROUNDS       (RN),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .soft_rst   (soft_rst),
        .start      (start),
        .user_guess (user_guess),
        .eval_now   (eval_now),
        .guess_now  (guess_now),
        .mole_pos   (mole_pos),
        .score      (score),
        .misses     (misses),
        .round_cnt  (round_cnt),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [7:0] lfsr_m = SEED;
    logic [2:0] prev_m = 3'd5;
    logic [2:0] last_seen = 3'd5;
    logic [2:0] pred;
    int         score_m = 0;
    int         misses_m = 0;
    int         round_m = 0;
    logic       st_eval [WT];
    logic [2:0] st_guess[WT];

    // Polynomial x^8+x^6+x^5+x^4+1: new bit = b7^b5^b4^b3, shifted in at the bottom.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [2:0] pick_hole(input logic [7:0] v, input logic [2:0] prev);
        int c;
        c = int'(v) % 8;
        if (c >= 5) c = c - 5;
        if (c == int'(prev)) c = (c + 1) % 5;
        return 3'(c);
    endfunction

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic tick;
        @(posedge clk);
        if (rst_n) lfsr_m = lfsr_step(lfsr_m);
        #1;
    endtask

    task automatic clear_stim;
        for (int i = 0; i < int'(WT); i++) begin
            st_eval[i]  = 1'b0;
            st_guess[i] = 3'd5;
        end
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
        score_m  = 0;
        misses_m = 0;
        round_m  = 0;
    endtask

    // Entered in the SPAWN cycle; leaves in WAIT cycle 1.
    task automatic spawn_to_wait(input string tag);
        pred    = pick_hole(lfsr_m, prev_m);
        prev_m  = pred;
        round_m = sat(round_m);
        tick;
        tests_run++;
        if (mole_pos !== pred) begin
            tests_failed++;
            $display("FAIL %s_mole_pos: got %0d expected %0d", tag, mole_pos, pred);
        end
        tests_run++;
        if (mole_pos === last_seen) begin
            tests_failed++;
            $display("FAIL %s_no_repeat: got %0d expected anything but %0d", tag, mole_pos, last_seen);
        end
        last_seen = mole_pos;
        tests_run++;
        if ({guess_now, round_cnt} !== {1'b1, 8'(round_m)}) begin
            tests_failed++;
            $display("FAIL %s_window_open: got guess_now=%0b round_cnt=%0d expected 1/%0d",
                     tag, guess_now, round_cnt, round_m);
        end
    endtask

    // Entered in WAIT cycle 1; applies st_eval/st_guess, then walks JUDGE and GAP.
    // Leaves in the SPAWN cycle of the next round, or the first OVER cycle.
    task automatic wait_and_judge(input string tag);
        logic hit;
        logic acc;
        hit = 1'b0;
        for (int c = 1; c <= int'(WT); c++) begin
            eval_now   = st_eval[c-1];
            user_guess = st_guess[c-1];
            acc = (c > 1) && st_eval[c-1] && (st_guess[c-1] < 3'd5);
            if (acc || c == int'(WT)) begin
                hit = acc && (st_guess[c-1] == pred);
                break;
            end
            tick;
            tests_run++;
            if (guess_now !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s_window_c%0d: got guess_now=%0b expected 1", tag, c + 1, guess_now);
            end
        end
        tick;
        eval_now   = 1'b0;
        user_guess = 3'd5;
        if (hit) score_m = sat(score_m);
        else     misses_m = sat(misses_m);
        tests_run++;
        if ({hit_pulse, miss_pulse, guess_now} !== {hit, ~hit, 1'b0}) begin
            tests_failed++;
            $display("FAIL %s_judge_pulse: got hit=%0b miss=%0b guess_now=%0b expected %0b/%0b/0",
                     tag, hit_pulse, miss_pulse, guess_now, hit, ~hit);
        end
        tests_run++;
        if ({score, misses} !== {8'(score_m), 8'(misses_m)}) begin
            tests_failed++;
            $display("FAIL %s_judge_counts: got score=%0d misses=%0d expected %0d/%0d",
                     tag, score, misses, score_m, misses_m);
        end
        for (int g = 1; g <= int'(GT); g++) begin
            tick;
            tests_run++;
            if ({mole_pos, hit_pulse, miss_pulse, guess_now} !== {3'd5, 3'b000}) begin
                tests_failed++;
                $display("FAIL %s_gap%0d: got mole_pos=%0d hit=%0b miss=%0b guess_now=%0b expected 5/0/0/0",
                         tag, g, mole_pos, hit_pulse, miss_pulse, guess_now);
            end
        end
        tick;
        tests_run++;
        if (game_over !== (round_m == int'(RN))) begin
            tests_failed++;
            $display("FAIL %s_game_over: got %0b expected %0b", tag, game_over, round_m == int'(RN));
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        tests_run++;
        if (guess_now !== 1'b0) begin tests_failed++; $display("FAIL reset_guess_now: got %0b expected 0", guess_now); end
        tests_run++;
        if (mole_pos !== 3'd5) begin tests_failed++; $display("FAIL reset_mole_pos: got %0d expected 5", mole_pos); end
        tests_run++;
        if ({score, misses, round_cnt} !== 24'd0) begin
            tests_failed++;
            $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", score, misses, round_cnt);
        end
        tests_run++;
        if ({hit_pulse, miss_pulse, game_over} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000", {hit_pulse, miss_pulse, game_over});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick;
        tests_run++;
        if ({guess_now, mole_pos} !== {1'b0, 3'd5}) begin
            tests_failed++;
            $display("FAIL idle_no_start: got guess_now=%0b mole_pos=%0d expected 0/5", guess_now, mole_pos);
        end
    endtask

    task automatic test_timeout;
        do_start;
        spawn_to_wait("timeout");
        clear_stim;
        wait_and_judge("timeout");
        tests_run++;
        if (misses !== 8'd1) begin tests_failed++; $display("FAIL timeout_misses: got %0d expected 1", misses); end
    endtask

    task automatic test_hit;
        spawn_to_wait("hit");
        clear_stim;
        st_eval[2]  = 1'b1;
        st_guess[2] = pred;
        wait_and_judge("hit");
    endtask

    task automatic test_stale_first;
        spawn_to_wait("stale");
        clear_stim;
        st_eval[0]  = 1'b1;
        st_guess[0] = pred;
        st_eval[1]  = 1'b1;
        st_guess[1] = (pred == 3'd4) ? 3'd0 : pred + 3'd1;
        wait_and_judge("stale");
    endtask

    task automatic test_game_over;
        tests_run++;
        if ({game_over, round_cnt, score, misses} !== {1'b1, 8'd3, 8'd1, 8'd2}) begin
            tests_failed++;
            $display("FAIL over_state: got game_over=%0b round=%0d score=%0d misses=%0d expected 1/3/1/2",
                     game_over, round_cnt, score, misses);
        end
        tick;
        do_start;
        tests_run++;
        if ({game_over, round_cnt, score, misses} !== 25'd0) begin
            tests_failed++;
            $display("FAIL restart_clear: got game_over=%0b round=%0d score=%0d misses=%0d expected 0/0/0/0",
                     game_over, round_cnt, score, misses);
        end
    endtask

    task automatic test_last_cycle_hit;
        spawn_to_wait("last_cycle");
        clear_stim;
        st_eval[WT-1]  = 1'b1;
        st_guess[WT-1] = pred;
        wait_and_judge("last_cycle");
    endtask

    task automatic test_random_rounds;
        for (int r = 0; r < 40; r++) begin
            if (round_m == int'(RN)) do_start;
            spawn_to_wait("random");
            for (int i = 0; i < int'(WT); i++) begin
                st_eval[i]  = ($urandom_range(0, 3) == 0);
                st_guess[i] = ($urandom_range(0, 2) == 0) ? pred : 3'($urandom_range(0, 5));
            end
            wait_and_judge("random");
        end
        if (round_m == int'(RN)) do_start;
    endtask

    task automatic test_soft_rst;
        spawn_to_wait("soft_rst");
        tick;
        tick;
        soft_rst = 1'b1;
        start    = 1'b1;
        tick;
        soft_rst = 1'b0;
        start    = 1'b0;
        score_m  = 0;
        misses_m = 0;
        round_m  = 0;
        tests_run++;
        if ({guess_now, mole_pos, score, misses, round_cnt, hit_pulse, miss_pulse, game_over}
            !== {1'b0, 3'd5, 24'd0, 3'b000}) begin
            tests_failed++;
            $display("FAIL soft_rst_outputs: got guess_now=%0b mole=%0d s=%0d m=%0d r=%0d flags=%b",
                     guess_now, mole_pos, score, misses, round_cnt, {hit_pulse, miss_pulse, game_over});
        end
        for (int i = 0; i < 3; i++) tick;
        tests_run++;
        if ({guess_now, mole_pos} !== {1'b0, 3'd5}) begin
            tests_failed++;
            $display("FAIL soft_rst_idle: got guess_now=%0b mole_pos=%0d expected 0/5", guess_now, mole_pos);
        end
        do_start;
        spawn_to_wait("after_soft_rst");
        clear_stim;
        st_eval[1]  = 1'b1;
        st_guess[1] = pred;
        wait_and_judge("after_soft_rst");
    endtask

    task automatic test_rst_in_gap;
        spawn_to_wait("rst_gap");
        for (int i = 0; i < int'(WT); i++) tick;
        tick;
        tick;
        tests_run++;
        if (mole_pos !== 3'd5) begin tests_failed++; $display("FAIL rst_gap_pre: got mole_pos=%0d expected 5", mole_pos); end
        rst_n = 1'b0;
        lfsr_m    = SEED;
        prev_m    = 3'd5;
        last_seen = 3'd5;
        score_m   = 0;
        misses_m  = 0;
        round_m   = 0;
        #1;
        tests_run++;
        if ({guess_now, mole_pos, score, misses, round_cnt, hit_pulse, miss_pulse, game_over}
            !== {1'b0, 3'd5, 24'd0, 3'b000}) begin
            tests_failed++;
            $display("FAIL rst_gap_outputs: got guess_now=%0b mole=%0d s=%0d m=%0d r=%0d flags=%b",
                     guess_now, mole_pos, score, misses, round_cnt, {hit_pulse, miss_pulse, game_over});
        end
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        tests_run++;
        if ({guess_now, miss_pulse} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rst_gap_idle: got guess_now=%0b miss=%0b expected 0/0", guess_now, miss_pulse);
        end
        do_start;
        spawn_to_wait("after_rst");
        clear_stim;
        wait_and_judge("after_rst");
    endtask

    initial begin
        test_reset;
        test_timeout;
        test_hit;
        test_stale_first;
        test_game_over;
        test_last_cycle_hit;
        test_random_rounds;
        test_soft_rst;
        test_rst_in_gap;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
